// File: rtl/mem_xfer_pkg.sv
// +----------------------------------------------------------------------------+
// | mem_xfer_pkg : shared state encoding and copy-mode constants for the       |
// |                two-memory transfer sequencer                               |
// | Revision     : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

package mem_xfer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_XFER = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic MODE_COPY_ALL  = 1'b0;
  localparam logic MODE_COPY_KEEP = 1'b1;

endpackage

`default_nettype wire

// File: rtl/seq_addr_counter.sv
// +----------------------------------------------------------------------------+
// | seq_addr_counter : clearable address counter that saturates at LIMIT-1     |
// | Revision         : 1.0                                                      |
// +----------------------------------------------------------------------------+
`default_nettype none

module seq_addr_counter #(
  parameter int LIMIT = 8,
  parameter int W     = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] value,
  output logic         last
);

  localparam logic [W-1:0] c_last = W'(LIMIT - 1);

  assign last = (value == c_last);

  // Clear wins over inc so a terminal cycle can rewind instead of advancing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (clear) begin
      value <= '0;
    end else if (inc && !last) begin
      value <= value + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_xfer_sequencer.sv
// +----------------------------------------------------------------------------+
// | mem_xfer_sequencer : fills memory A, then copies all or comparator-kept    |
// |                      words into memory B with fill/overflow reporting      |
// | Revision           : 1.0                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module mem_xfer_sequencer
  import mem_xfer_pkg::*;
#(
  parameter int DEPTH_A = 8,
  parameter int DEPTH_B = 8,
  parameter int AW_A    = $clog2(DEPTH_A),
  parameter int AW_B    = $clog2(DEPTH_B)
) (
  input  logic            clock,
  input  logic            Reset,
  input  logic            start,
  input  logic            mode,
  input  logic            keep,
  output logic            WEA,
  output logic            IncA,
  output logic [AW_A-1:0] AddrA,
  output logic            WEB,
  output logic            IncB,
  output logic [AW_B-1:0] AddrB,
  output logic [AW_B:0]   count_b,
  output logic            b_full,
  output logic            overflow,
  output logic            busy,
  output logic            done
);

  localparam logic [AW_B:0] c_count_full = (AW_B + 1)'(DEPTH_B);

  state_t        r_state;
  state_t        w_next;
  logic          r_mode;
  logic [AW_B:0] r_count_b;
  logic          r_overflow;
  logic          w_clr_a;
  logic          w_clr_b;
  logic          w_last_a;
  logic          w_last_b;
  logic          w_qual;
  logic          w_drop;

  seq_addr_counter #(
    .LIMIT (DEPTH_A),
    .W     (AW_A)
  ) u_cnt_a (
    .clk   (clock),
    .rst   (Reset),
    .clear (w_clr_a),
    .inc   (IncA),
    .value (AddrA),
    .last  (w_last_a)
  );

  seq_addr_counter #(
    .LIMIT (DEPTH_B),
    .W     (AW_B)
  ) u_cnt_b (
    .clk   (clock),
    .rst   (Reset),
    .clear (w_clr_b),
    .inc   (IncB),
    .value (AddrB),
    .last  (w_last_b)
  );

  assign w_qual   = (r_mode != MODE_COPY_KEEP) | keep;
  assign b_full   = w_last_b & (r_count_b == c_count_full);
  assign IncB     = WEB;
  assign count_b  = r_count_b;
  assign overflow = r_overflow;

  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    WEA     = 1'b0;
    IncA    = 1'b0;
    WEB     = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    w_clr_a = 1'b0;
    w_clr_b = 1'b0;
    w_drop  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_clr_a = 1'b1;
          w_clr_b = 1'b1;
          w_next  = ST_FILL;
        end
      end
      ST_FILL: begin
        WEA  = 1'b1;
        IncA = 1'b1;
        busy = 1'b1;
        // Rewind A so the scan phase starts at word 0.
        if (w_last_a) begin
          w_clr_a = 1'b1;
          w_next  = ST_XFER;
        end
      end
      ST_XFER: begin
        IncA = 1'b1;
        busy = 1'b1;
        if (w_qual) begin
          if (b_full) begin
            w_drop = 1'b1;
          end else begin
            WEB = 1'b1;
          end
        end
        if (w_last_a) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      r_mode     <= MODE_COPY_ALL;
      r_count_b  <= '0;
      r_overflow <= 1'b0;
    end else if (w_clr_b) begin
      r_mode     <= mode;
      r_count_b  <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (WEB) begin
        r_count_b <= r_count_b + 1'b1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_xfer_sequencer.sv
// +----------------------------------------------------------------------------+
// | tb_mem_xfer_sequencer : three parameterisations driven from shared inputs  |
// | Revision              : 1.0                                                 |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mem_xfer_sequencer;

  logic clock = 1'b0;
  logic Reset, start, mode, keep;

  logic wea [3], inca [3], web [3], incb [3], bfull [3], ovf_o [3], busy [3], done_o [3];
  logic [2:0] addra0, addra1, addra2, addrb0, addrb2;
  logic [1:0] addrb1;
  logic [3:0] cnt0, cnt2;
  logic [2:0] cnt1;
  logic [20:0] obs [3];

  always #5 clock = ~clock;

  mem_xfer_sequencer #(.DEPTH_A(8), .DEPTH_B(8)) u0 (
    .clock(clock), .Reset(Reset), .start(start), .mode(mode), .keep(keep),
    .WEA(wea[0]), .IncA(inca[0]), .AddrA(addra0), .WEB(web[0]), .IncB(incb[0]),
    .AddrB(addrb0), .count_b(cnt0), .b_full(bfull[0]), .overflow(ovf_o[0]),
    .busy(busy[0]), .done(done_o[0]));

  mem_xfer_sequencer #(.DEPTH_A(8), .DEPTH_B(4)) u1 (
    .clock(clock), .Reset(Reset), .start(start), .mode(mode), .keep(keep),
    .WEA(wea[1]), .IncA(inca[1]), .AddrA(addra1), .WEB(web[1]), .IncB(incb[1]),
    .AddrB(addrb1), .count_b(cnt1), .b_full(bfull[1]), .overflow(ovf_o[1]),
    .busy(busy[1]), .done(done_o[1]));

  mem_xfer_sequencer #(.DEPTH_A(5), .DEPTH_B(8)) u2 (
    .clock(clock), .Reset(Reset), .start(start), .mode(mode), .keep(keep),
    .WEA(wea[2]), .IncA(inca[2]), .AddrA(addra2), .WEB(web[2]), .IncB(incb[2]),
    .AddrB(addrb2), .count_b(cnt2), .b_full(bfull[2]), .overflow(ovf_o[2]),
    .busy(busy[2]), .done(done_o[2]));

  // Field layout: busy done wea inca web incb b_full overflow addra[4] addrb[4] count[5]
  assign obs[0] = {busy[0], done_o[0], wea[0], inca[0], web[0], incb[0], bfull[0], ovf_o[0],
                   1'b0, addra0, 1'b0, addrb0, 1'b0, cnt0};
  assign obs[1] = {busy[1], done_o[1], wea[1], inca[1], web[1], incb[1], bfull[1], ovf_o[1],
                   1'b0, addra1, 2'b0, addrb1, 2'b0, cnt1};
  assign obs[2] = {busy[2], done_o[2], wea[2], inca[2], web[2], incb[2], bfull[2], ovf_o[2],
                   1'b0, addra2, 1'b0, addrb2, 1'b0, cnt2};

  // Reference model: ph = cycles elapsed since the accepting edge (0 = idle).
  int da [3] = '{8, 8, 5};
  int db [3] = '{8, 4, 8};
  int ph [3], cnt [3], ahold [3];
  bit ovf [3], ml [3];
  int n_chk = 0, n_pass = 0, cyc = 0;

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      ph[i] = 0; cnt[i] = 0; ahold[i] = 0; ovf[i] = 1'b0; ml[i] = 1'b0;
    end
  endfunction

  function automatic logic [20:0] model_out(input int i);
    int  d = da[i];
    int  b = db[i];
    int  p = ph[i];
    int  aa, ab;
    logic bs, dn, we, xf, wb;
    bs = (p >= 1) && (p <= 2 * d);
    dn = (p == 2 * d + 1);
    we = (p >= 1) && (p <= d);
    xf = (p > d) && (p <= 2 * d);
    wb = xf && (!ml[i] || keep) && (cnt[i] < b);
    aa = we ? p - 1 : (xf ? p - d - 1 : ahold[i]);
    ab = (cnt[i] < b) ? cnt[i] : b - 1;
    return {bs, dn, we, bs, wb, wb, logic'(cnt[i] == b), ovf[i], 4'(aa), 4'(ab), 5'(cnt[i])};
  endfunction

  function automatic void model_step(input int i);
    int d = da[i];
    int b = db[i];
    if (ph[i] == 0) begin
      if (start) begin
        ph[i] = 1; cnt[i] = 0; ovf[i] = 1'b0; ml[i] = mode;
      end
    end else begin
      if (ph[i] > d && ph[i] <= 2 * d && (!ml[i] || keep)) begin
        if (cnt[i] < b) cnt[i]++;
        else ovf[i] = 1'b1;
      end
      if (ph[i] == 2 * d) ahold[i] = d - 1;
      ph[i] = (ph[i] == 2 * d + 1) ? 0 : ph[i] + 1;
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic sample();
    @(negedge clock);
    for (int i = 0; i < 3; i++)
      chk($sformatf("model u%0d cyc%0d", i, cyc), 32'(obs[i]), 32'(model_out(i)));
  endtask

  task automatic step_edge();
    @(posedge clock);
    cyc++;
    if (!Reset) for (int i = 0; i < 3; i++) model_step(i);
    #1;
  endtask

  task automatic drain(input int n);
    start = 1'b0;
    for (int c = 0; c < n; c++) begin
      keep = 1'($urandom);
      sample();
      step_edge();
    end
  endtask

  typedef struct {
    logic       md;
    logic [7:0] kp;     // bit j = keep in XFER cycle j+1
    int         cnt0;
    logic [7:0] web0;
    int         cnt1;
    logic       ovf1;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int done_r0, done_r2, dones, gap;
    logic [7:0] webobs;

    tbl[0] = '{1'b0, 8'h00, 8, 8'hFF, 4, 1'b1};
    tbl[1] = '{1'b1, 8'h4D, 4, 8'h4D, 4, 1'b0};
    tbl[2] = '{1'b1, 8'hFF, 8, 8'hFF, 4, 1'b1};
    tbl[3] = '{1'b1, 8'h00, 0, 8'h00, 0, 1'b0};
    tbl[4] = '{1'b1, 8'hF1, 5, 8'hF1, 4, 1'b1};
    tbl[5] = '{1'b0, 8'h5A, 8, 8'hFF, 4, 1'b1};

    Reset = 1'b1; start = 1'b0; mode = 1'b0; keep = 1'b0;
    model_reset();
    sample();
    for (int i = 0; i < 3; i++) chk($sformatf("reset u%0d", i), 32'(obs[i]), 32'd0);
    step_edge();
    Reset = 1'b0;
    drain(2);

    // Directed runs from the vector table.
    for (int v = 0; v < 6; v++) begin
      start = 1'b1; mode = tbl[v].md; keep = 1'b0;
      sample();
      step_edge();
      start = 1'b0;
      done_r0 = -1; done_r2 = -1; webobs = '0;
      for (int r = 1; r <= 18; r++) begin
        keep = (r >= 9 && r <= 16) ? tbl[v].kp[r-9] : 1'($urandom);
        sample();
        if (r >= 9 && r <= 16) webobs[r-9] = web[0];
        if (done_o[0]) done_r0 = r;
        if (done_o[2]) done_r2 = r;
        step_edge();
      end
      chk($sformatf("v%0d web0 pattern", v), 32'(webobs), 32'(tbl[v].web0));
      chk($sformatf("v%0d done0 cycle", v), done_r0, 17);
      chk($sformatf("v%0d done2 cycle", v), done_r2, 11);
      chk($sformatf("v%0d count_b0", v), 32'(cnt0), tbl[v].cnt0);
      chk($sformatf("v%0d b_full0", v), 32'(bfull[0]), 32'(tbl[v].cnt0 == 8));
      chk($sformatf("v%0d overflow0", v), 32'(ovf_o[0]), 32'd0);
      chk($sformatf("v%0d count_b1", v), 32'(cnt1), tbl[v].cnt1);
      chk($sformatf("v%0d overflow1", v), 32'(ovf_o[1]), 32'(tbl[v].ovf1));
      chk($sformatf("v%0d addrb1", v), 32'(addrb1), (tbl[v].cnt1 < 4) ? tbl[v].cnt1 : 3);
      chk($sformatf("v%0d b_full1", v), 32'(bfull[1]), 32'(tbl[v].cnt1 == 4));
    end

    // Start held high: exactly one idle cycle between back-to-back runs.
    start = 1'b1; mode = 1'b0;
    dones = 0; gap = 0;
    for (int c = 0; c < 80 && dones < 2; c++) begin
      keep = 1'($urandom);
      sample();
      if (dones == 1 && !busy[0] && !done_o[0]) gap++;
      if (done_o[0]) dones++;
      step_edge();
    end
    chk("held start runs", dones, 2);
    chk("held start idle gap", gap, 1);
    drain(20);

    // Asynchronous reset during FILL with AddrA = 3.
    start = 1'b1; mode = 1'b0;
    sample();
    step_edge();
    start = 1'b0;
    for (int r = 1; r <= 3; r++) begin
      sample();
      step_edge();
    end
    chk("pre-reset addra0", 32'(addra0), 32'd3);
    Reset = 1'b1;
    model_reset();
    #1;
    for (int i = 0; i < 3; i++) chk($sformatf("async reset u%0d", i), 32'(obs[i]), 32'd0);
    sample();
    step_edge();
    Reset = 1'b0;
    start = 1'b1; mode = 1'b1;
    sample();
    step_edge();
    start = 1'b0;
    chk("restart addra0", 32'(addra0), 32'd0);
    chk("restart busy0", 32'(busy[0]), 32'd1);
    chk("restart overflow1", 32'(ovf_o[1]), 32'd0);
    drain(20);

    // Randomised traffic including occasional resets.
    for (int c = 0; c < 600; c++) begin
      Reset = ($urandom_range(0, 49) == 0);
      if (Reset) model_reset();
      start = ($urandom_range(0, 2) == 0);
      mode  = 1'($urandom);
      keep  = 1'($urandom);
      sample();
      step_edge();
    end
    Reset = 1'b0;
    drain(20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_xfer_sequencer.md
# mem_xfer_sequencer

Parametrised control sequencer for the two-memory transfer datapath. On a start request it fills memory A with `DEPTH_A` consecutive words, then scans memory A and writes either every word or only comparator-qualified words into memory B. It generates write enables, address increments and registered addresses for both memories, and reports completion, fill level and overflow. It generalises the fixed 19-count controller to arbitrary depths, adds a conditional-copy mode and adds a start/done handshake.

## Interface
- `DEPTH_A`, default 8: words written to and scanned from memory A; minimum 2; need not be a power of two.
- `DEPTH_B`, default 8: capacity of memory B; minimum 2.
- `AW_A`, default `$clog2(DEPTH_A)`: memory A address width.
- `AW_B`, default `$clog2(DEPTH_B)`: memory B address width.
- `clock`  in  1  single clock; all state changes on the rising edge.
- `Reset`  in  1  asynchronous, active-high; clears all state immediately.
- `start`  in  1  run request; sampled only in IDLE.
- `mode`  in  1  0 = copy all, 1 = copy only when `keep`=1; sampled with `start`, then held internally.
- `keep`  in  1  comparator result for the word at the current `AddrA`; combinational read, valid the same cycle.
- `WEA`  out  1  memory A write enable.
- `IncA`  out  1  `AddrA` advances at the next edge.
- `AddrA`  out  AW_A  registered memory A address.
- `WEB`  out  1  memory B write enable.
- `IncB`  out  1  `AddrB` advances at the next edge; equal to `WEB`.
- `AddrB`  out  AW_B  registered memory B address.
- `count_b`  out  AW_B+1  words written to B in the current or last run.
- `b_full`  out  1  `count_b == DEPTH_B`.
- `overflow`  out  1  sticky; a qualifying word was dropped because B was full.
- `busy`  out  1  high in FILL and XFER.
- `done`  out  1  one-cycle pulse at the end of a run.

## Operation
- States are IDLE, FILL, XFER and DONE.
- **Reset:**
  - State goes to IDLE.
  - All outputs are 0, including `AddrA`, `AddrB`, `count_b` and `overflow`.
- **IDLE:**
  - All strobes are 0.
  - If `start`=1: `AddrA` is cleared to 0, `AddrB` to 0, `count_b` to 0 and `overflow` to 0. `mode` is latched. Next state is FILL.
- **FILL:**
  - `WEA`=1 and `IncA`=1 every cycle.
  - When `AddrA == DEPTH_A-1`: `AddrA` is cleared to 0 instead of incrementing, and next state is XFER.
- **XFER:**
  - `IncA`=1 every cycle.
  - `qual = (mode_latched==0) | keep`.
  - If `qual` and not `b_full`: `WEB`=1, `IncB`=1, `count_b` increments and `AddrB` increments. `AddrB` is clamped at `DEPTH_B-1`, so it never wraps.
  - If `qual` and `b_full`: `overflow` is set and there is no write.
  - When `AddrA == DEPTH_A-1`: next state is DONE.
- **DONE:**
  - `done`=1 and all strobes are 0.
  - Next state is IDLE.
  - `AddrB`, `count_b` and `overflow` hold until the next accepted `start`.
- `start` is ignored in FILL, XFER and DONE.
- `AddrA` never exceeds `DEPTH_A-1`. Terminal detection compares against `DEPTH_A-1` and never relies on counter width wrap.

## Timing
- Let `start` be accepted at edge t.
- **FILL:** occupies cycles t+1 through t+DEPTH_A. `AddrA` is 0 in the first of these cycles.
- **XFER:** occupies cycles t+DEPTH_A+1 through t+2·DEPTH_A.
- **Completion:**
  - `done` is high in cycle t+2·DEPTH_A+1.
  - `busy` falls in that same cycle.
  - The earliest next acceptance is edge t+2·DEPTH_A+2.
- `WEA`, `IncA`, `busy` and `done` decode from state only.
- `WEB`/`IncB` are combinational from `keep` in XFER; this is the only input-to-output path.
- Address and count outputs are registered and update at the edge following their increment strobe.
- `Reset` asserted mid-run forces all outputs to 0 without waiting for a clock edge. Deassertion is synchronised by the integrator.

## Structure
- **Package `mem_xfer_pkg`:** contains the state enum (`ST_IDLE`, `ST_FILL`, `ST_XFER`, `ST_DONE`) and the mode constants `MODE_COPY_ALL`=0 and `MODE_COPY_KEEP`=1.
- **Sub-module `seq_addr_counter`:**
  - Parameters `LIMIT` and `W`.
  - Inputs `clear` and `inc`; output `last` = (value == `LIMIT`-1).
  - Saturates at `LIMIT`-1.
  - Used twice, once for A and once for B.
- The FSM, `count_b` and `overflow` live in the top module.

## Test plan
- **Copy all:** `DEPTH_A`=8, `DEPTH_B`=8, `mode`=0, pulse `start`.
  - `WEA` high for 8 cycles with `AddrA` 0..7.
  - Then `WEB` high for 8 cycles with `AddrB` 0..7.
  - `done` in cycle t+17; `count_b`=8, `b_full`=1, `overflow`=0.
- **Conditional copy:** `mode`=1, `keep` per XFER cycle = 1,0,1,1,0,0,1,0.
  - `WEB` high exactly in XFER cycles 1, 3, 4 and 7, with `AddrB` 0,1,2,3.
  - `count_b`=4, `overflow`=0.
- **B overflow:** `DEPTH_B`=4, `mode`=0.
  - 4 writes only; `b_full` high from the 5th XFER cycle.
  - `overflow`=1, `AddrB` holds at 3.
  - `done` still in cycle t+17.
- **Reset mid-run:** assert `Reset` in FILL with `AddrA`=3.
  - All outputs go to 0 before the next edge; state is IDLE.
  - A new `start` restarts with `AddrA`=0 and `overflow` cleared.
- **Start held high:** hold `start`=1 throughout.
  - It is ignored while `busy` and in DONE.
  - Consecutive runs are separated by exactly one IDLE cycle.
- **Non-power-of-two depth:** `DEPTH_A`=5.
  - `AddrA` takes only values 0..4 in both phases.
  - `done` in cycle t+11.
